// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] PWM_PERIOD_MAX = 8'd254;
    localparam int NUM_OUTPUTS = 16;

    // Width of a counter holding 0..prescale-1; never narrower than one bit.
    function automatic int presc_cnt_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/pwm_output_stage_prescaler.sv
// Free-running clk divider: tick is high on the last cycle of every PRESCALE-cycle window.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = presc_cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_cnt_q;
    logic [CW-1:0] presc_cnt_d;

    assign tick = (presc_cnt_q == LAST);

    always_comb begin
        presc_cnt_d = presc_cnt_q + CW'(1);
        if (tick) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// 16-pin output stage: each pin is forced low, forced high or follows one shared PWM waveform.
// Define PWM_SHADOW_DUTY_EN to latch the duty cycle only at period boundaries.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             en_reg_out_7_0,
    input  logic [7:0]             en_reg_out_15_8,
    input  logic [7:0]             en_reg_pwm_7_0,
    input  logic [7:0]             en_reg_pwm_15_8,
    input  logic [7:0]             pwm_duty_cycle,
    output logic [NUM_OUTPUTS-1:0] out,
    output logic                   period_start
);

    logic                   tick;
    logic                   wrap;
    logic [PWM_CNT_W-1:0]   pwm_cnt_q;
    logic [PWM_CNT_W-1:0]   pwm_cnt_d;
    logic [PWM_CNT_W-1:0]   duty_eff;
    logic                   pwm_raw;
    logic [NUM_OUTPUTS-1:0] en_out;
    logic [NUM_OUTPUTS-1:0] en_pwm;
    logic [NUM_OUTPUTS-1:0] out_q;
    logic [NUM_OUTPUTS-1:0] out_d;
    logic                   period_start_q;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Period is 0..254 so that duty 0xFF stays high through the whole period.
    assign wrap = tick && (pwm_cnt_q == PWM_PERIOD_MAX);

    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (wrap) begin
            pwm_cnt_d = '0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_CNT_W'(1);
        end
    end

`ifdef PWM_SHADOW_DUTY_EN
    logic [PWM_CNT_W-1:0] duty_shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_q <= '0;
        end else if (wrap) begin
            duty_shadow_q <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    assign pwm_raw = (pwm_cnt_q < duty_eff);
    assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_pin
        assign out_d[gi] = en_out[gi] & (~en_pwm[gi] | pwm_raw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with PRESCALE=1 and PRESCALE=4 instances sharing stimulus.
module tb_pwm_output_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out1, out4;
    logic        ps1, ps4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_output_stage #(.PRESCALE(1)) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_reg_out_7_0 (eo_lo),
        .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0 (ep_lo),
        .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle (duty),
        .out            (out1),
        .period_start   (ps1)
    );

    pwm_output_stage #(.PRESCALE(4)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_reg_out_7_0 (eo_lo),
        .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0 (ep_lo),
        .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle (duty),
        .out            (out4),
        .period_start   (ps4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: got %0h", tag, obs);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
    endtask

    // Wait for a period_start pulse; n is the number of negedges it took.
    task automatic wait_ps(input bit sel, input int limit, output int n);
        bit found;
        logic p;
        found = 1'b0;
        n = 0;
        p = 1'b0;
        while (!found && n < limit) begin
            @(negedge clk);
            n++;
            p = sel ? ps4 : ps1;
            if (p) found = 1'b1;
        end
        if (!found) check("wait_ps_timeout", {31'd0, p}, 32'd1);
    endtask

    // Sample len cycles after a period_start; out at sample i reflects pwm_cnt of sample i-1.
    task automatic measure(input bit sel, input int len, input int chg_at, input logic [7:0] new_duty,
                           output int hi, output int last_hi, output int ps_pos, output logic others);
        logic [15:0] o;
        logic        p;
        hi = 0;
        last_hi = 0;
        ps_pos = 0;
        others = 1'b0;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            o = sel ? out4 : out1;
            p = sel ? ps4 : ps1;
            if (o[0]) begin
                hi++;
                last_hi = i;
            end
            if (|o[15:1]) others = 1'b1;
            if (p && ps_pos == 0) ps_pos = i;
            if (i == chg_at) duty = new_duty;
        end
    endtask

    initial begin
        int   n, hi, last_hi, ps_pos;
        logic others;

        // 1: reset with every input nonzero
        rst_n = 1'b0;
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_out1", {16'd0, out1}, 32'd0);
            check("rst_ps1", {31'd0, ps1}, 32'd0);
            check("rst_out4", {16'd0, out4}, 32'd0);
        end
        rst_n = 1'b1;
        set_en(16'h0000, 16'h0000);
        #1;
        check("rel_out1", {16'd0, out1}, 32'd0);
        @(negedge clk);
        check("rel1_out1", {16'd0, out1}, 32'd0);
        check("rel1_ps1", {31'd0, ps1}, 32'd0);

        // 2: static high pins, then disable
        set_en(16'h8001, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("static_out1", {16'd0, out1}, 32'h8001);
            check("static_out4", {16'd0, out4}, 32'h8001);
        end
        set_en(16'h0000, 16'h0000);
        @(negedge clk);
        check("disable_out1", {16'd0, out1}, 32'd0);

        // 3: duty 0x80 on pin 0, two periods
        set_en(16'h0001, 16'h0001);
        duty = 8'h80;
        wait_ps(1'b0, 300, n);
        for (int k = 0; k < 2; k++) begin
            measure(1'b0, 255, 0, 8'h00, hi, last_hi, ps_pos, others);
            check("d80_high", hi, 32'd128);
            check("d80_high_first", last_hi, 32'd128);
            check("d80_ps_spacing", ps_pos, 32'd255);
            check("d80_others", {31'd0, others}, 32'd0);
        end

        // 4: duty extremes over three periods each
        duty = 8'h00;
        wait_ps(1'b0, 300, n);
        for (int k = 0; k < 3; k++) begin
            measure(1'b0, 255, 0, 8'h00, hi, last_hi, ps_pos, others);
            check("d00_high", hi, 32'd0);
            check("d00_ps_spacing", ps_pos, 32'd255);
        end
        duty = 8'hFF;
        wait_ps(1'b0, 300, n);
        for (int k = 0; k < 3; k++) begin
            measure(1'b0, 255, 0, 8'h00, hi, last_hi, ps_pos, others);
            check("dff_high", hi, 32'd255);
            check("dff_ps_spacing", ps_pos, 32'd255);
        end

        // 5: duty 0x40 -> 0xC0 while pwm_cnt == 10
        duty = 8'h40;
        wait_ps(1'b0, 300, n);
        measure(1'b0, 255, 10, 8'hC0, hi, last_hi, ps_pos, others);
`ifdef PWM_SHADOW_DUTY_EN
        check("chg_cur_high", hi, 32'd64);
        check("chg_cur_run", last_hi, 32'd64);
`else
        check("chg_cur_high", hi, 32'd192);
        check("chg_cur_run", last_hi, 32'd192);
`endif
        measure(1'b0, 255, 0, 8'h00, hi, last_hi, ps_pos, others);
        check("chg_next_high", hi, 32'd192);
        check("chg_next_run", last_hi, 32'd192);

        // 6: PRESCALE=4, reset asserted at pwm_cnt == 100
        set_en(16'h0003, 16'h0001);
        duty = 8'h10;
        wait_ps(1'b1, 1100, n);
        repeat (400) @(negedge clk);
        check("p4_pre_rst_out", {16'd0, out4}, 32'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("p4_async_out4", {16'd0, out4}, 32'd0);
        check("p4_async_out1", {16'd0, out1}, 32'd0);
        repeat (3) @(negedge clk);
        check("p4_in_rst_ps", {31'd0, ps4}, 32'd0);
        rst_n = 1'b1;
        wait_ps(1'b1, 1100, n);
        check("p4_first_ps", n, 32'd1020);
        measure(1'b1, 1020, 0, 8'h00, hi, last_hi, ps_pos, others);
        check("p4_high", hi, 32'd64);
        check("p4_high_first", last_hi, 32'd64);
        check("p4_ps_spacing", ps_pos, 32'd1020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
Downstream consumer of the SPI register bank. It takes the five configuration registers (output enables, PWM enables, duty cycle) and drives 16 registered output pins. Each pin is one of three things: forced low, forced high, or a shared PWM waveform. The waveform uses a prescaled 8-bit period counter, so the PWM frequency can be configured independently of clk.

Parameters:
PRESCALE, 13, clk cycles per PWM counter tick (legal range 1..65535)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  output enable for out[7:0]
en_reg_out_15_8  input  8  output enable for out[15:8]
en_reg_pwm_7_0  input  8  PWM select for out[7:0]
en_reg_pwm_15_8  input  8  PWM select for out[15:8]
pwm_duty_cycle  input  8  duty, 0x00 = 0%, 0xFF = 100%
out  output  16  driven pin values
period_start  output  1  one-clk pulse at the start of each PWM period

Behaviour:
- Reset (async assert, sync release) sets: prescaler counter 0, pwm_cnt 0, duty_shadow 0, out 16'h0000, period_start 0.
- Prescaler
  - presc_cnt counts 0..PRESCALE-1 and then wraps to 0.
  - tick = (presc_cnt == PRESCALE-1).
  - With PRESCALE=1, tick is high every cycle.
- Period counter
  - On tick, pwm_cnt advances 0..254 and wraps 254 -> 0.
  - Period is 255 ticks, i.e. 255*PRESCALE clk cycles.
  - pwm_cnt never reaches 255.
- period_start
  - Registered.
  - High for exactly one clk: the first cycle in which pwm_cnt == 0 following a 254 -> 0 wrap.
  - Not asserted for the initial 0 after reset.
- Duty comparison
  - pwm_raw = (pwm_cnt < duty_eff), 8-bit unsigned.
  - duty 0x00 gives pwm_raw always 0.
  - duty 0xFF gives pwm_raw always 1, because pwm_cnt ≤ 254.
  - duty N gives exactly N high ticks per period, high ticks first in the period.
- Output mapping, bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - out[i] next = en_out[i] & (~en_pwm[i] | pwm_raw).
  - en_out=0 forces low regardless of en_pwm.
  - en_out=1, en_pwm=0 gives static high.
  - en_out=1, en_pwm=1 gives the PWM waveform.
- Latency
  - out is registered.
  - A change on the enable inputs is visible on out one clk later.
  - Enables are NOT shadowed and take effect immediately.
- Simultaneous events
  - Enable change and period wrap in the same cycle: the new enables combine with the new period's pwm_raw.
- Reset mid-period: counters restart from 0 and out clears immediately (asynchronously).
- Inputs are synchronous to clk; no CDC inside this block.

Optional Feature:
PWM_SHADOW_DUTY_EN
- Defined:
  - duty_eff = duty_shadow.
  - duty_shadow loads pwm_duty_cycle on the tick where pwm_cnt wraps 254 -> 0.
  - A duty change therefore takes effect only at the next period boundary, giving glitch-free periods.
  - After reset, duty_eff is 0 until the first wrap.
- Undefined:
  - duty_shadow is not implemented.
  - duty_eff = pwm_duty_cycle directly, so a change affects the current period from the next tick onward.

Decomposition:
- Package pwm_pkg holds:
  - PWM_CNT_W = 8
  - PWM_PERIOD_MAX = 8'd254
  - NUM_OUTPUTS = 16
  - a function computing the prescaler counter width from PRESCALE
- One sub-module, pwm_prescaler: parameter PRESCALE; ports clk, rst_n, tick. It encapsulates presc_cnt.
- Counter, shadow, compare and output mapping stay in pwm_output_stage.

Test Plan:
1. Reset, with all inputs nonzero during reset -> out == 16'h0000 and period_start == 0 throughout reset, and on the first cycle after release.
2. PRESCALE=1, en_out=16'h8001, en_pwm=0 -> out == 16'h8001 one clk after the inputs are applied and remains constant; en_out -> 0 clears out on the next clk.
3. PRESCALE=1, shadow on, en_out=en_pwm=16'h0001, duty=0x80:
   - After the first period_start, out[0] is high for 128 and low for 127 clks in every period.
   - period_start pulses spaced 255 clks apart.
   - out[15:1] stay 0.
4. Duty extremes, PRESCALE=1, one pin in PWM mode, measured over 3 full periods after the boundary:
   - duty 0x00 -> out[i] constant 0.
   - duty 0xFF -> out[i] constant 1.
5. Shadow on, PRESCALE=1, duty 0x40, switched to 0xC0 at pwm_cnt=10 -> current period shows 64 high clks; following period shows 192. With shadow off, the same stimulus gives the current period a high run from count 0 up to count 191.
6. PRESCALE=4, duty 0x10, with rst_n asserted mid-period at pwm_cnt=100:
   - out clears asynchronously.
   - After release, period_start spacing is 1020 clks.
   - High time per period is 64 clks.
